// File: rtl/chg_pkg.sv
// chg_pkg: shared state encoding, coin values and sizing helper for the
// change dispenser (change_dispenser and chg_gap_timer).
package chg_pkg;

   // Payout FSM states
   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EMIT,
      ST_GAP,
      ST_DONE
   } chg_state_e;

   // Coin values in 10-yen units
   localparam int unsigned FIF_UNITS = 5;
   localparam int unsigned TEN_UNITS = 1;

   // Bits needed to hold 0..max_val; never less than one bit
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/chg_gap_timer.sv
// chg_gap_timer: idle-gap counter between coin pulses. A load sets the
// count to GAP-1; while enabled it counts down to zero and holds there.
// zero_o flags that the gap has elapsed.
module chg_gap_timer
   import chg_pkg::*;
#(
   parameter int GAP = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic load_i,
   input  logic en_i,
   output logic zero_o
);

   localparam int unsigned   TW       = cnt_width(GAP);
   localparam logic [TW-1:0] LOAD_VAL = TW'(GAP - 1);

   logic [TW-1:0] cnt_q;
   logic [TW-1:0] cnt_d;

   // Next count: load has priority, otherwise count down and stop at zero
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = LOAD_VAL;
      end else if (en_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   // Counter register with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/change_dispenser.sv
// change_dispenser: pays out a change amount (10-yen units) as single-cycle
// coin pulses, greedy 50-yen first then 10-yen, with GAP idle cycles between
// pulses and a one-cycle done pulse after the last coin.
// Optional feature macro CHG_STOCK_EN: finite 50-yen stock (FIF_STOCK coins
// loaded at reset); once exhausted the remainder is paid in 10-yen coins.
module change_dispenser
   import chg_pkg::*;
#(
   parameter int AW        = 4,
   parameter int GAP       = 2,
   parameter int FIF_STOCK = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req_valid,
   input  logic [AW-1:0] req_amount,
   output logic          req_ready,
   output logic          ten_out,
   output logic          fif_out,
   output logic          busy,
   output logic          done
);

   // Parameter legality: remainder must hold a 50-yen value, at least one
   // gap cycle, non-negative stock
   if ((AW < 3) || (GAP < 1) || (FIF_STOCK < 0)) begin : g_param_check
      $error("change_dispenser: need AW>=3, GAP>=1, FIF_STOCK>=0");
   end

   localparam logic [AW-1:0] FIF_A = AW'(FIF_UNITS);
   localparam logic [AW-1:0] TEN_A = AW'(TEN_UNITS);

   chg_state_e    state_q;
   chg_state_e    state_d;
   logic [AW-1:0] rem_q;
   logic [AW-1:0] rem_d;
   logic [AW-1:0] rem_sub;
   logic          tmr_load;
   logic          tmr_en;
   logic          tmr_zero;
   logic          fif_avail;

   chg_gap_timer #(
      .GAP (GAP)
   ) u_gap_timer (
      .clk    (clk),
      .rst    (rst),
      .load_i (tmr_load),
      .en_i   (tmr_en),
      .zero_o (tmr_zero)
   );

`ifdef CHG_STOCK_EN
   localparam int unsigned SW = cnt_width(FIF_STOCK);

   logic [SW-1:0] stock_q;
   logic [SW-1:0] stock_d;

   // One 50-yen coin leaves the stock per fif_out pulse
   always_comb begin
      stock_d = stock_q;
      if (fif_out && (stock_q != '0)) begin
         stock_d = stock_q - 1'b1;
      end
   end

   // Stock register, refilled only by reset
   always_ff @(posedge clk) begin
      if (rst) begin
         stock_q <= SW'(FIF_STOCK);
      end else begin
         stock_q <= stock_d;
      end
   end

   assign fif_avail = (stock_q != '0);
`else
   assign fif_avail = 1'b1;
`endif

   // FSM next state, remainder update and output decode
   always_comb begin
      state_d   = state_q;
      rem_d     = rem_q;
      rem_sub   = rem_q;
      req_ready = 1'b0;
      ten_out   = 1'b0;
      fif_out   = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      tmr_load  = 1'b0;
      tmr_en    = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               rem_d   = req_amount;
               state_d = (req_amount == '0) ? ST_DONE : ST_EMIT;
            end
         end

         ST_EMIT: begin
            busy = 1'b1;
            if ((rem_q >= FIF_A) && fif_avail) begin
               fif_out = 1'b1;
               rem_sub = rem_q - FIF_A;
            end else if (rem_q >= TEN_A) begin
               ten_out = 1'b1;
               rem_sub = rem_q - TEN_A;
            end
            rem_d = rem_sub;
            if (rem_sub == '0) begin
               state_d = ST_DONE;
            end else begin
               state_d  = ST_GAP;
               tmr_load = 1'b1;
            end
         end

         ST_GAP: begin
            busy = 1'b1;
            if (tmr_zero) begin
               state_d = ST_EMIT;
            end else begin
               tmr_en = 1'b1;
            end
         end

         ST_DONE: begin
            done    = 1'b1;
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and remainder registers; reset abandons any payout in progress
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         rem_q   <= '0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
      end
   end

endmodule
